// File: rtl/outbuf_pkg.sv
// Shared types and helpers for the output-buffer read path.
// Used by the drain master and the psum-side loader.
package outbuf_pkg;

    localparam int DEF_DATA_WIDTH = 33;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } drain_state_t;

    // Clip a signed partial sum to the output range; returns {sat, data}.
    function automatic logic [DEF_OUT_WIDTH:0] sat_to_out(
        input logic [DEF_DATA_WIDTH-1:0] din
    );
        logic signed [DEF_DATA_WIDTH-1:0] v;
        logic signed [DEF_DATA_WIDTH-1:0] hi;
        logic signed [DEF_DATA_WIDTH-1:0] lo;
        v  = din;
        hi = {{(DEF_DATA_WIDTH-DEF_OUT_WIDTH+1){1'b0}},
              {(DEF_OUT_WIDTH-1){1'b1}}};
        lo = ~hi;
        if (v > hi)
            sat_to_out = {2'b10, {(DEF_OUT_WIDTH-1){1'b1}}};
        else if (v < lo)
            sat_to_out = {2'b11, {(DEF_OUT_WIDTH-1){1'b0}}};
        else
            sat_to_out = {1'b0, din[DEF_OUT_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Small synchronous result FIFO between the saturator and the host stream.
// Head data reads as zero while empty so the stream outputs idle at 0.
module drain_skid_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; push+pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty     = (count == '0);
    assign occupancy = count;
    assign pop_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/outbuf_drain.sv
// Read-side master for the accelerator output buffer: pops a fixed number
// of words, saturates them and streams them to the host collector.
module outbuf_drain
    import outbuf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  expected_count,
    input  logic                  outbuf_empty,
    input  logic [DATA_WIDTH-1:0] outbuf_dout,
    output logic                  outbuf_ren,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [OUT_WIDTH-1:0]  res_data,
    output logic                  res_sat,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  sat_count
);

    localparam int AW = $clog2(SKID_DEPTH);

    drain_state_t         state;
    logic [CNT_WIDTH-1:0] target;
    logic [CNT_WIDTH-1:0] issued;
    logic [CNT_WIDTH-1:0] accepted;
    logic                 inflight;
    logic                 hs;
    logic                 skid_empty;
    logic [AW:0]          occupancy;
    logic [AW+1:0]        credit_used;
    logic [OUT_WIDTH:0]   sat_word;
    logic [OUT_WIDTH:0]   head;

    assign hs        = res_valid & res_ready;
    assign res_valid = !skid_empty;
    assign res_sat   = head[OUT_WIDTH];
    assign res_data  = head[OUT_WIDTH-1:0];
    assign sat_word  = sat_to_out(outbuf_dout);

    // Slots already claimed: stored words plus the word in flight, less
    // the one leaving this cycle, which keeps one word per cycle sustained.
    assign credit_used = {1'b0, occupancy}
                       + {{(AW+1){1'b0}}, inflight}
                       - {{(AW+1){1'b0}}, hs};

    assign outbuf_ren = (state == DRAIN)
                      && !outbuf_empty
                      && (issued < target)
                      && (credit_used < (AW+2)'(SKID_DEPTH));

    drain_skid_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (sat_word),
        .pop       (hs),
        .pop_data  (head),
        .empty     (skid_empty),
        .occupancy (occupancy)
    );

    // Job FSM with issue/accept counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            issued    <= '0;
            accepted  <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_count <= '0;
        end else begin
            inflight <= outbuf_ren;
            done     <= 1'b0;
            if (outbuf_ren)
                issued <= issued + 1'b1;
            if (hs) begin
                accepted <= accepted + 1'b1;
                if (res_sat && sat_count != '1)
                    sat_count <= sat_count + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        target    <= expected_count;
                        issued    <= '0;
                        accepted  <= '0;
                        sat_count <= '0;
                        busy      <= 1'b1;
                        state     <= (expected_count == '0) ? FIN : DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && (accepted + 1'b1) == target)
                        state <= FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outbuf_drain.sv
// Self-checking bench for outbuf_drain: a queue-fed outbuf model,
// a stream collector and an arithmetic saturation reference.
module tb_outbuf_drain;

    localparam int DW = 33;
    localparam int OW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] expected_count = '0;
    logic          outbuf_empty;
    logic [DW-1:0] outbuf_dout = '0;
    logic          outbuf_ren;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [OW-1:0] res_data;
    logic          res_sat;
    logic          busy;
    logic          done;
    logic [CW-1:0] sat_count;

    int passed = 0;
    int total  = 0;

    // outbuf model: src[] written by stimulus, src_rd advanced on pops
    logic [DW-1:0] src [0:1023];
    int            src_wr = 0;
    int            src_rd = 0;
    logic          flush = 1'b0;
    logic          ren_s = 1'b0;

    // collector / event log, written only by the negedge monitor
    logic [OW:0]   got_q [0:1023];
    int            got_n = 0;
    int            ren_cnt = 0;
    int            under_cnt = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            last_hs_cyc = 0;
    int            done_cyc = 0;

    logic [OW:0]   exp_q [$];

    outbuf_drain dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .expected_count (expected_count),
        .outbuf_empty   (outbuf_empty),
        .outbuf_dout    (outbuf_dout),
        .outbuf_ren     (outbuf_ren),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_sat        (res_sat),
        .busy           (busy),
        .done           (done),
        .sat_count      (sat_count)
    );

    always #5 clk = ~clk;

    assign outbuf_empty = (src_rd == src_wr);

    always @(posedge clk) begin
        if (flush)
            src_rd <= src_wr;
        else if (ren_s && src_rd != src_wr) begin
            outbuf_dout <= src[src_rd];
            src_rd      <= src_rd + 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        ren_s = outbuf_ren;
        if (outbuf_ren) begin
            ren_cnt++;
            if (outbuf_empty)
                under_cnt++;
        end
        if (res_valid && res_ready && !rst) begin
            got_q[got_n] = {res_sat, res_data};
            got_n++;
            last_hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [OW:0] model_sat(input longint v);
        if (v > 32767)
            return {1'b1, 16'h7fff};
        if (v < -32768)
            return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    function automatic longint rand_word();
        return longint'($urandom_range(0, 140000)) - 70000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_val(input longint v);
        src[src_wr] = DW'(v);
        src_wr++;
        exp_q.push_back(model_sat(v));
    endtask

    task automatic push_raw(input longint v);
        src[src_wr] = DW'(v);
        src_wr++;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        expected_count = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done_cnt > d0)
                ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if (outbuf_ren !== 1'b0)
            $display("FAIL reset_ren: got %b want 0", outbuf_ren);
        else passed++;
        total++;
        if (res_valid !== 1'b0)
            $display("FAIL reset_valid: got %b want 0", res_valid);
        else passed++;
        total++;
        if ({res_sat, res_data} !== 17'h0)
            $display("FAIL reset_data: got %h want 0", {res_sat, res_data});
        else passed++;
        total++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        else passed++;
        total++;
        if (sat_count !== '0)
            $display("FAIL reset_satcnt: got %0d want 0", sat_count);
        else passed++;
    endtask

    task automatic test_words(input string name, input longint w0,
                              input longint w1, input longint w2,
                              input longint w3, input int want_sat);
        int g0, r0, d0;
        bit ok;
        exp_q.delete();
        g0 = got_n;
        r0 = ren_cnt;
        d0 = done_cnt;
        res_ready = 1'b1;
        push_val(w0);
        push_val(w1);
        push_val(w2);
        push_val(w3);
        pulse_start(4);
        wait_done(60, ok);
        repeat (3) tick();
        total++;
        if (!ok) $display("FAIL %s_done_timeout: got none want 1", name);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_n - g0 <= i || got_q[g0+i] !== exp_q[i])
                $display("FAIL %s_word%0d: got %h want %h", name, i,
                         got_q[g0+i], exp_q[i]);
            else passed++;
        end
        total++;
        if (ren_cnt - r0 != 4)
            $display("FAIL %s_ren_cycles: got %0d want 4", name, ren_cnt - r0);
        else passed++;
        total++;
        if (done_cnt - d0 != 1)
            $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt - d0);
        else passed++;
        total++;
        if (sat_count !== CW'(want_sat))
            $display("FAIL %s_sat_count: got %0d want %0d", name, sat_count,
                     want_sat);
        else passed++;
    endtask

    task automatic test_basic();
        test_words("basic", 1, 2, -3, 100, 0);
    endtask

    task automatic test_saturation();
        test_words("sat", 40000, -40000, 32767, -32768, 2);
    endtask

    task automatic test_backpressure();
        int g0, r0;
        bit ok;
        exp_q.delete();
        g0 = got_n;
        r0 = ren_cnt;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            push_val(rand_word());
        pulse_start(6);
        repeat (10) tick();
        total++;
        if (ren_cnt - r0 != 2)
            $display("FAIL bp_pops_held: got %0d want 2", ren_cnt - r0);
        else passed++;
        total++;
        if (outbuf_ren !== 1'b0 || got_n != g0)
            $display("FAIL bp_stalled: got ren=%b n=%0d want 0 0", outbuf_ren,
                     got_n - g0);
        else passed++;
        res_ready = 1'b1;
        wait_done(60, ok);
        total++;
        if (!ok || got_n - g0 != 6)
            $display("FAIL bp_count: got %0d want 6", got_n - g0);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got_q[g0+i] !== exp_q[i])
                $display("FAIL bp_word%0d: got %h want %h", i, got_q[g0+i],
                         exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_starved();
        int g0, r0, u0, d0, drop;
        exp_q.delete();
        g0 = got_n;
        r0 = ren_cnt;
        u0 = under_cnt;
        d0 = done_cnt;
        drop = 0;
        res_ready = 1'b1;
        pulse_start(3);
        for (int c = 0; c < 60 && done_cnt == d0; c++) begin
            if (c == 0 || c == 5 || c == 12)
                push_val(rand_word());
            tick();
            if (!busy && !done && done_cnt == d0)
                drop++;
        end
        total++;
        if (done_cnt == d0)
            $display("FAIL starve_done_timeout: got none want 1");
        else passed++;
        total++;
        if (drop != 0)
            $display("FAIL starve_busy: got %0d low cycles want 0", drop);
        else passed++;
        total++;
        if (under_cnt != u0 || ren_cnt - r0 != 3)
            $display("FAIL starve_ren: got %0d pops %0d empty want 3 0",
                     ren_cnt - r0, under_cnt - u0);
        else passed++;
        total++;
        if (got_n - g0 != 3)
            $display("FAIL starve_count: got %0d want 3", got_n - g0);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q[g0+i] !== exp_q[i])
                $display("FAIL starve_word%0d: got %h want %h", i,
                         got_q[g0+i], exp_q[i]);
            else passed++;
        end
        total++;
        if (done_cyc <= last_hs_cyc || done_cyc - last_hs_cyc > 2)
            $display("FAIL starve_done_after_hs: got %0d want 1..2",
                     done_cyc - last_hs_cyc);
        else passed++;
    endtask

    task automatic test_zero_and_ignored();
        int g0, r0;
        bit ok;
        r0 = ren_cnt;
        pulse_start(0);
        total++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL zero_t1: got done=%b busy=%b want 0 1", done, busy);
        else passed++;
        tick();
        total++;
        if (done !== 1'b1)
            $display("FAIL zero_t2_done: got %b want 1", done);
        else passed++;
        tick();
        total++;
        if (done !== 1'b0 || ren_cnt != r0)
            $display("FAIL zero_after: got done=%b pops=%0d want 0 0", done,
                     ren_cnt - r0);
        else passed++;

        exp_q.delete();
        g0 = got_n;
        r0 = ren_cnt;
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            push_val(rand_word());
        pulse_start(3);
        pulse_start(7);
        push_raw(rand_word());
        push_raw(rand_word());
        wait_done(60, ok);
        repeat (4) tick();
        total++;
        if (!ok || got_n - g0 != 3 || ren_cnt - r0 != 3)
            $display("FAIL ignored_start: got n=%0d pops=%0d want 3 3",
                     got_n - g0, ren_cnt - r0);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q[g0+i] !== exp_q[i])
                $display("FAIL ignored_word%0d: got %h want %h", i,
                         got_q[g0+i], exp_q[i]);
            else passed++;
        end
        do_flush();
    endtask

    task automatic test_reset_mid();
        int g0, r0;
        bit ok;
        logic signed [DW-1:0] w;
        logic [OW:0] want;
        exp_q.delete();
        g0 = got_n;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            push_val(rand_word());
        pulse_start(5);
        for (int i = 0; i < 40 && got_n - g0 < 2; i++)
            tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (got_n - g0 != 2 || got_q[g0] !== exp_q[0]
            || got_q[g0+1] !== exp_q[1])
            $display("FAIL rstmid_pre: got n=%0d want 2 matching", got_n - g0);
        else passed++;
        total++;
        if ({outbuf_ren, res_valid, res_sat, res_data, busy, done} !== '0
            || sat_count !== '0)
            $display("FAIL rstmid_outputs: got %b want all 0",
                     {outbuf_ren, res_valid, res_sat, busy, done});
        else passed++;
        push_raw(rand_word());
        w = src[src_rd];
        want = model_sat(longint'(w));
        g0 = got_n;
        r0 = ren_cnt;
        pulse_start(1);
        wait_done(40, ok);
        total++;
        if (!ok || got_n - g0 != 1 || got_q[g0] !== want || ren_cnt - r0 != 1)
            $display("FAIL rstmid_next: got %h n=%0d want %h n=1",
                     got_q[g0], got_n - g0, want);
        else passed++;
        do_flush();
    endtask

    task automatic test_random();
        int g0, r0, u0, nsat;
        bit ok;
        exp_q.delete();
        g0 = got_n;
        r0 = ren_cnt;
        u0 = under_cnt;
        d_loop: begin end
        for (int i = 0; i < 20; i++)
            push_val(rand_word());
        nsat = 0;
        for (int i = 0; i < 20; i++)
            if (exp_q[i][OW]) nsat++;
        pulse_start(20);
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            res_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) ok = 1'b1;
        end
        res_ready = 1'b1;
        total++;
        if (!ok || got_n - g0 != 20)
            $display("FAIL rand_count: got %0d want 20", got_n - g0);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (got_q[g0+i] !== exp_q[i])
                $display("FAIL rand_word%0d: got %h want %h", i, got_q[g0+i],
                         exp_q[i]);
            else passed++;
        end
        total++;
        if (sat_count !== CW'(nsat) || ren_cnt - r0 != 20 || under_cnt != u0)
            $display("FAIL rand_stats: got sat=%0d pops=%0d want %0d 20",
                     sat_count, ren_cnt - r0, nsat);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_starved();
        test_zero_and_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
